// File: rtl/mcu_dispatch.sv
// mcu_dispatch: routes MCU link frames to one of four target units, answers
// local register reads, and merges target interrupts onto one active-low line.
// Optional build macro MCU_DISPATCH_TIMEOUT_EN adds the idle-frame timeout
// and the abort counter. Without it the abort counter always reads 0x00.
module mcu_dispatch #(
  parameter logic [19:0] TIMEOUT_CYCLES = 20'd100000,
  parameter logic [7:0]  VERSION        = 8'h01
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_in_strobe,
  input  logic        data_in_start,
  input  logic [7:0]  data_in,
  output logic [7:0]  data_out,
  output logic [3:0]  tgt_strobe,
  output logic        tgt_start,
  output logic [7:0]  tgt_data,
  input  logic [31:0] tgt_dout,
  input  logic [3:0]  tgt_int,
  output logic        int_out_n,
  output logic        frame_active
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUTE = 2'd1,
    ST_LOCAL = 2'd2,
    ST_DROP  = 2'd3
  } state_t;

  state_t      state_reg, state_next;
  logic [1:0]  sel_reg;
  logic        first_fwd_reg;
  logic [3:0]  k_reg;
  logic [3:0]  k_cur;
  logic [7:0]  reply_reg;
  logic [3:0]  tgt_strobe_reg;
  logic        tgt_start_reg;
  logic [7:0]  tgt_data_reg;
  logic [3:0]  int_mask_reg;
  logic        int_out_n_reg;
  logic [7:0]  abort_cnt_reg;
  logic        timeout_hit;
  logic        start_evt;
  logic        byte_evt;
  logic        abort_clear;

  assign start_evt   = data_in_strobe & data_in_start;
  assign byte_evt    = data_in_strobe & ~data_in_start;
  // Local byte index of the byte arriving now; sticks at 15.
  assign k_cur       = (k_reg == 4'hF) ? 4'hF : k_reg + 4'd1;
  assign abort_clear = byte_evt && (state_reg == ST_LOCAL) && (k_cur == 4'd2);

`ifdef MCU_DISPATCH_TIMEOUT_EN
  logic [19:0] tmo_cnt_reg;

  // Any strobe is a sign of life; only a silent open frame reaches the limit.
  assign timeout_hit = (state_reg != ST_IDLE) && !data_in_strobe &&
                       (tmo_cnt_reg == TIMEOUT_CYCLES - 20'd1);

  // Idle-frame watchdog counter.
  always_ff @(posedge clk) begin
    if (reset || data_in_strobe || state_reg == ST_IDLE || timeout_hit)
      tmo_cnt_reg <= 20'd0;
    else
      tmo_cnt_reg <= tmo_cnt_reg + 20'd1;
  end

  // Abort counter: a read-clear wins over a coincident increment.
  always_ff @(posedge clk) begin
    if (reset || abort_clear)
      abort_cnt_reg <= 8'h00;
    else if (timeout_hit && abort_cnt_reg != 8'hFF)
      abort_cnt_reg <= abort_cnt_reg + 8'd1;
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign timeout_hit    = 1'b0;
  assign abort_cnt_reg  = 8'h00;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_reg <= ST_IDLE;
    else       state_reg <= state_next;
  end

  // Next state: a start byte always opens a new frame, whatever came before.
  always_comb begin
    state_next = state_reg;
    if (start_evt) begin
      if (data_in[7:2] == 6'd0)  state_next = ST_ROUTE;
      else if (data_in == 8'h0F) state_next = ST_LOCAL;
      else                       state_next = ST_DROP;
    end else if (timeout_hit) begin
      state_next = ST_IDLE;
    end
  end

  // Frame datapath: forwarding registers, local register replies, int mask.
  always_ff @(posedge clk) begin
    if (reset) begin
      sel_reg        <= 2'd0;
      first_fwd_reg  <= 1'b0;
      k_reg          <= 4'd0;
      reply_reg      <= 8'h00;
      tgt_strobe_reg <= 4'd0;
      tgt_start_reg  <= 1'b0;
      tgt_data_reg   <= 8'h00;
      int_mask_reg   <= 4'hF;
    end else begin
      tgt_strobe_reg <= 4'd0;
      tgt_start_reg  <= 1'b0;
      if (start_evt) begin
        sel_reg       <= data_in[1:0];
        first_fwd_reg <= 1'b1;
        k_reg         <= 4'd0;
        reply_reg     <= {4'hA, tgt_int};
      end else if (byte_evt) begin
        case (state_reg)
          ST_ROUTE: begin
            tgt_strobe_reg <= 4'b0001 << sel_reg;
            tgt_start_reg  <= first_fwd_reg;
            tgt_data_reg   <= data_in;
            first_fwd_reg  <= 1'b0;
          end
          ST_LOCAL: begin
            k_reg <= k_cur;
            case (k_cur)
              4'd1: begin
                int_mask_reg <= data_in[3:0];
                reply_reg    <= {4'h0, tgt_int};
              end
              4'd2:    reply_reg <= abort_cnt_reg;
              4'd3:    reply_reg <= VERSION;
              default: reply_reg <= 8'h00;
            endcase
          end
          default: ;
        endcase
      end
    end
  end

  // Interrupt line follows the masked request with one cycle of latency.
  always_ff @(posedge clk) begin
    if (reset) int_out_n_reg <= 1'b1;
    else       int_out_n_reg <= ~|(tgt_int & int_mask_reg);
  end

  // Reply mux: live target byte while routing, silence while dropping.
  always_comb begin
    data_out = reply_reg;
    case (state_reg)
      ST_ROUTE: data_out = tgt_dout[{sel_reg, 3'b000} +: 8];
      ST_DROP:  data_out = 8'h00;
      default:  data_out = reply_reg;
    endcase
  end

  // Reset kills an in-flight forwarded strobe immediately, not one edge later.
  assign tgt_strobe   = reset ? 4'd0 : tgt_strobe_reg;
  assign tgt_start    = reset ? 1'b0 : tgt_start_reg;
  assign tgt_data     = tgt_data_reg;
  assign int_out_n    = int_out_n_reg;
  assign frame_active = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_mcu_dispatch.sv
// tb_mcu_dispatch: table-driven directed vectors for mcu_dispatch plus
// hand-written reset and (when enabled) timeout sequences.
module tb_mcu_dispatch;

`ifdef MCU_DISPATCH_TIMEOUT_EN
  localparam logic [19:0] TB_TMO = 20'd16;
`else
  localparam logic [19:0] TB_TMO = 20'd100000;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        data_in_strobe;
  logic        data_in_start;
  logic [7:0]  data_in;
  logic [7:0]  data_out;
  logic [3:0]  tgt_strobe;
  logic        tgt_start;
  logic [7:0]  tgt_data;
  logic [31:0] tgt_dout;
  logic [3:0]  tgt_int;
  logic        int_out_n;
  logic        frame_active;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mcu_dispatch #(.TIMEOUT_CYCLES(TB_TMO), .VERSION(8'h01)) dut (
    .clk(clk), .reset(reset),
    .data_in_strobe(data_in_strobe), .data_in_start(data_in_start),
    .data_in(data_in), .data_out(data_out),
    .tgt_strobe(tgt_strobe), .tgt_start(tgt_start), .tgt_data(tgt_data),
    .tgt_dout(tgt_dout), .tgt_int(tgt_int),
    .int_out_n(int_out_n), .frame_active(frame_active)
  );

  typedef struct {
    logic       st;
    logic       sb;
    logic [7:0] din;
    logic [3:0] ti;
    logic [7:0] e_dout;
    logic [3:0] e_stb;
    logic       e_start;
    logic [7:0] e_data;
    logic       e_fa;
    logic       e_intn;
  } vec_t;

  vec_t vecs[24];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Present one cycle of input, clock it in, sample just after the edge.
  task automatic step(input logic st, input logic sb, input logic [7:0] din, input logic [3:0] ti);
    data_in_start  = st;
    data_in_strobe = sb;
    data_in        = din;
    tgt_int        = ti;
    @(posedge clk);
    #1;
    data_in_strobe = 1'b0;
    data_in_start  = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_dout"},  {24'd0, data_out}, 32'h00);
    chk({tag, "_stb"},   {28'd0, tgt_strobe}, 32'h0);
    chk({tag, "_start"}, {31'd0, tgt_start}, 32'h0);
    chk({tag, "_data"},  {24'd0, tgt_data}, 32'h00);
    chk({tag, "_intn"},  {31'd0, int_out_n}, 32'h1);
    chk({tag, "_fa"},    {31'd0, frame_active}, 32'h0);
  endtask

  initial begin
    // start  sb   din    ti     dout   stb      sta  data   fa    intn
    vecs[0]  = '{1'b1, 1'b1, 8'h02, 4'h0, 8'h33, 4'b0000, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[1]  = '{1'b0, 1'b1, 8'h10, 4'h0, 8'h33, 4'b0100, 1'b1, 8'h10, 1'b1, 1'b1};
    vecs[2]  = '{1'b0, 1'b1, 8'h55, 4'h0, 8'h33, 4'b0100, 1'b0, 8'h55, 1'b1, 1'b1};
    vecs[3]  = '{1'b0, 1'b0, 8'h00, 4'h0, 8'h33, 4'b0000, 1'b0, 8'h55, 1'b1, 1'b1};
    vecs[4]  = '{1'b1, 1'b1, 8'h0F, 4'h8, 8'hA8, 4'b0000, 1'b0, 8'h55, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 8'h07, 4'h8, 8'h08, 4'b0000, 1'b0, 8'h55, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 8'h00, 4'h8, 8'h08, 4'b0000, 1'b0, 8'h55, 1'b1, 1'b1};
    vecs[7]  = '{1'b1, 1'b1, 8'h0F, 4'h8, 8'hA8, 4'b0000, 1'b0, 8'h55, 1'b1, 1'b1};
    vecs[8]  = '{1'b0, 1'b1, 8'h0F, 4'h8, 8'h08, 4'b0000, 1'b0, 8'h55, 1'b1, 1'b1};
    vecs[9]  = '{1'b0, 1'b0, 8'h00, 4'h8, 8'h08, 4'b0000, 1'b0, 8'h55, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 8'h00, 4'h8, 8'h00, 4'b0000, 1'b0, 8'h55, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 8'h00, 4'h8, 8'h01, 4'b0000, 1'b0, 8'h55, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 8'h00, 4'h8, 8'h00, 4'b0000, 1'b0, 8'h55, 1'b1, 1'b0};
    vecs[13] = '{1'b1, 1'b1, 8'h07, 4'h0, 8'h00, 4'b0000, 1'b0, 8'h55, 1'b1, 1'b1};
    vecs[14] = '{1'b0, 1'b1, 8'h21, 4'h0, 8'h00, 4'b0000, 1'b0, 8'h55, 1'b1, 1'b1};
    vecs[15] = '{1'b0, 1'b1, 8'h22, 4'h0, 8'h00, 4'b0000, 1'b0, 8'h55, 1'b1, 1'b1};
    vecs[16] = '{1'b0, 1'b1, 8'h23, 4'h0, 8'h00, 4'b0000, 1'b0, 8'h55, 1'b1, 1'b1};
    vecs[17] = '{1'b0, 1'b0, 8'h00, 4'h0, 8'h00, 4'b0000, 1'b0, 8'h55, 1'b1, 1'b1};
    vecs[18] = '{1'b1, 1'b1, 8'h00, 4'h0, 8'h11, 4'b0000, 1'b0, 8'h55, 1'b1, 1'b1};
    vecs[19] = '{1'b0, 1'b1, 8'hAB, 4'h0, 8'h11, 4'b0001, 1'b1, 8'hAB, 1'b1, 1'b1};
    vecs[20] = '{1'b1, 1'b1, 8'h01, 4'h0, 8'h22, 4'b0000, 1'b0, 8'hAB, 1'b1, 1'b1};
    vecs[21] = '{1'b0, 1'b1, 8'hCD, 4'h0, 8'h22, 4'b0010, 1'b1, 8'hCD, 1'b1, 1'b1};
    vecs[22] = '{1'b0, 1'b1, 8'hEF, 4'h0, 8'h22, 4'b0010, 1'b0, 8'hEF, 1'b1, 1'b1};
    vecs[23] = '{1'b0, 1'b0, 8'h00, 4'h0, 8'h22, 4'b0000, 1'b0, 8'hEF, 1'b1, 1'b1};

    reset          = 1'b1;
    data_in_strobe = 1'b0;
    data_in_start  = 1'b0;
    data_in        = 8'h00;
    tgt_int        = 4'h0;
    tgt_dout       = 32'h44332211;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_state("reset");
    reset = 1'b0;

    for (int i = 0; i < 24; i++) begin
      step(vecs[i].st, vecs[i].sb, vecs[i].din, vecs[i].ti);
      $display("vec %0d: st=%0b sb=%0b din=%02h ti=%h -> dout=%02h stb=%b start=%0b data=%02h fa=%0b intn=%0b",
               i, vecs[i].st, vecs[i].sb, vecs[i].din, vecs[i].ti,
               data_out, tgt_strobe, tgt_start, tgt_data, frame_active, int_out_n);
      chk($sformatf("v%0d_dout", i),  {24'd0, data_out},     {24'd0, vecs[i].e_dout});
      chk($sformatf("v%0d_stb", i),   {28'd0, tgt_strobe},   {28'd0, vecs[i].e_stb});
      chk($sformatf("v%0d_start", i), {31'd0, tgt_start},    {31'd0, vecs[i].e_start});
      chk($sformatf("v%0d_data", i),  {24'd0, tgt_data},     {24'd0, vecs[i].e_data});
      chk($sformatf("v%0d_fa", i),    {31'd0, frame_active}, {31'd0, vecs[i].e_fa});
      chk($sformatf("v%0d_intn", i),  {31'd0, int_out_n},    {31'd0, vecs[i].e_intn});
    end

    // Reset coinciding with a routed byte: nothing may be forwarded.
    step(1'b1, 1'b1, 8'h03, 4'h0);
    reset = 1'b1;
    step(1'b0, 1'b1, 8'h77, 4'h0);
    $display("reset-on-strobe: stb=%b fa=%0b dout=%02h", tgt_strobe, frame_active, data_out);
    chk_reset_state("rst_strobe");
    reset = 1'b0;

    // Reset raised while a forwarded strobe is on the wire cancels it at once.
    step(1'b1, 1'b1, 8'h03, 4'h0);
    step(1'b0, 1'b1, 8'h99, 4'h0);
    chk("pre_rst_stb", {28'd0, tgt_strobe}, 32'h8);
    reset = 1'b1;
    #1;
    $display("reset-mid-strobe: stb=%b start=%0b", tgt_strobe, tgt_start);
    chk("rst_cancel_stb",   {28'd0, tgt_strobe}, 32'h0);
    chk("rst_cancel_start", {31'd0, tgt_start}, 32'h0);
    @(posedge clk);
    #1;
    chk_reset_state("rst_mid");
    reset = 1'b0;

`ifdef MCU_DISPATCH_TIMEOUT_EN
    begin
      int fall;
      fall = 0;
      step(1'b1, 1'b1, 8'h01, 4'h0);
      for (int i = 1; i <= 20; i++) begin
        step(1'b0, 1'b0, 8'h00, 4'h0);
        if (!frame_active && fall == 0) fall = i;
      end
      $display("timeout: frame_active fell after %0d idle cycles", fall);
      chk("tmo_fall_cycle", fall, 16);
      step(1'b1, 1'b1, 8'h0F, 4'h0);
      step(1'b0, 1'b1, 8'h0F, 4'h0);
      step(1'b0, 1'b1, 8'h00, 4'h0);
      $display("timeout: abort_cnt read %02h", data_out);
      chk("tmo_abort_read1", {24'd0, data_out}, 32'h01);
      step(1'b1, 1'b1, 8'h0F, 4'h0);
      step(1'b0, 1'b1, 8'h0F, 4'h0);
      step(1'b0, 1'b1, 8'h00, 4'h0);
      $display("timeout: abort_cnt reread %02h", data_out);
      chk("tmo_abort_read2", {24'd0, data_out}, 32'h00);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mcu_dispatch.md
MCU_DISPATCH -- requirements
Module: mcu_dispatch

Interface
REQ-001 Parameter TIMEOUT_CYCLES, 20'd100000: idle clk cycles inside a frame before a forced abort.
REQ-002 Parameter VERSION, 8'h01: value returned by local register byte 3.
REQ-003 clk  in  1  system clock; all logic is single-clock on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 data_in_strobe  in  1  one-cycle pulse per byte from MCU link.
REQ-006 data_in_start  in  1  qualifies strobe as first byte of a frame.
REQ-007 data_in  in  8  MCU byte.
REQ-008 data_out  out  8  byte returned to MCU.
REQ-009 tgt_strobe  out  4  one-hot forwarded strobe; bit n targets unit n (0 sysctrl, 1 hid, 2 osd, 3 sdc).
REQ-010 tgt_start  out  1  marks first forwarded byte (command byte) of a frame.
REQ-011 tgt_data  out  8  forwarded byte, shared by all targets.
REQ-012 tgt_dout  in  32  target reply bytes, target n on bits [8n+7:8n].
REQ-013 tgt_int  in  4  level interrupt requests, bit n from target n.
REQ-014 int_out_n  out  1  active-low interrupt line to MCU.
REQ-015 frame_active  out  1  high while state is not IDLE.

Function
REQ-016 States: IDLE, ROUTE, LOCAL, DROP; start strobe is honoured in every state and aborts any frame in progress without a timeout count.
REQ-017 Start strobe: data_in 0x00-0x03 -> ROUTE with sel=data_in[1:0]; 0x0F -> LOCAL; any other value -> DROP; start byte itself is never forwarded.
REQ-018 Start strobe: data_out <= {4'hA, tgt_int}, visible the cycle after the strobe.
REQ-019 ROUTE, non-start strobe: next cycle tgt_strobe[sel]=1 for exactly one cycle, tgt_data=data_in, tgt_start=1 only for the first forwarded byte of the frame, else 0.
REQ-020 ROUTE: data_out is a combinational mux of tgt_dout[sel]; all other states drive the internal reply register.
REQ-021 LOCAL byte index k (1st non-start byte k=1): k=1 writes int_mask<=data_in[3:0] and replies {4'h0, tgt_int}; k=2 replies abort_cnt then clears it; k=3 replies VERSION; k>=4 replies 0x00; k saturates at 15.
REQ-022 DROP: strobes ignored, data_out=0x00, no tgt_strobe.
REQ-023 int_out_n registered: low one cycle after (tgt_int & int_mask)!=0, high one cycle after it becomes 0.
REQ-024 abort_cnt 8-bit, increments on timeout abort, saturates at 0xFF; a clear at REQ-021 k=2 coinciding with an increment leaves it at 0.
REQ-025 At most one tgt_strobe bit asserted in any cycle.

Reset
REQ-026 Reset: state IDLE, tgt_strobe 0, tgt_start 0, tgt_data 0x00, data_out 0x00, int_mask 4'hF, abort_cnt 0, timeout counter 0, int_out_n 1, frame_active 0.
REQ-027 Reset asserted mid-frame drops the frame; a pending forwarded strobe is cancelled in the same cycle.

Configuration
REQ-028 Macro MCU_DISPATCH_TIMEOUT_EN defined: counter clears on every data_in_strobe, counts in non-IDLE states, and at TIMEOUT_CYCLES-1 forces IDLE and increments abort_cnt.
REQ-029 Macro undefined: no timeout counter, frames end only on a new start or reset, abort_cnt reads constant 0x00.

Verification
REQ-030 Start 0x02, bytes 0x10,0x55 -> tgt_strobe=4'b0100 twice, tgt_start 1 then 0, tgt_data 0x10 then 0x55, data_out follows tgt_dout[23:16].
REQ-031 tgt_int=4'b1000, start 0x0F, byte 0x07 -> data_out 0xA8 then 0x08; int_out_n rises 1 cycle later (masked); start 0x0F, byte 0x0F -> int_out_n falls 1 cycle later.
REQ-032 Start 0x07, 3 bytes -> no tgt_strobe, data_out 0x00, frame_active 1 until next start.
REQ-033 Start 0x00, one byte, then start 0x01 with no gap -> no strobe for start byte, next byte goes to target 1 with tgt_start=1.
REQ-034 With MCU_DISPATCH_TIMEOUT_EN, TIMEOUT_CYCLES=16: start 0x01, wait 20 cycles -> frame_active 0 at cycle 16; LOCAL read k=2 returns 0x01, next read 0x00.
REQ-035 Reset during ROUTE strobe cycle -> tgt_strobe stays 0, all outputs match REQ-026.
